// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the BMP frame writer.
// Build option: define ROW_PAD_EN to pad rows to 4-byte boundaries.
package frame_writer_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PIXEL_SIZE      = 24;
  localparam int unsigned WORD_SIZE       = 8;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    PAD,
    DONE
  } state_t;

  // Number of zero bytes that bring one row of 3-byte pixels up to a multiple of 4.
  function automatic logic [1:0] row_pad(input int unsigned w);
    return 2'((4 - ((BYTES_PER_PIXEL * w) % 4)) % 4);
  endfunction

endpackage

// File: rtl/bmp_frame_writer_if.sv
// Pixel stream in, byte-wide memory port out.
// The master side is the pixel source that also observes the memory port;
// the slave side is the frame writer.
interface bmp_frame_writer_if #(
  parameter int unsigned ADDR_W = 24
);
  import frame_writer_pkg::*;

  logic                  en;
  logic                  hsync;
  logic                  vsync;
  logic [PIXEL_SIZE-1:0] data;
  logic                  ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;

  modport master (
    output en, hsync, vsync, data,
    input  ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  en, hsync, vsync, data,
    output ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/frame_addr_gen.sv
// Column/row tracking and byte address generation for the frame writer.
// col/row/row_start describe where the next accepted pixel lands; last_col
// and last_row describe the pixel currently being written out.
module frame_addr_gen
  import frame_writer_pkg::*;
#(
  parameter int unsigned width     = 640,
  parameter int unsigned height    = 480,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned STRIDE    = 1920
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              next_byte,    // emit the following byte of the current pixel/pad
  input  logic              take_pixel,   // a pixel is accepted this cycle
  input  logic              start_frame,  // accepted pixel carries vsync
  input  logic              abandon_row,  // accepted pixel carries hsync mid-row
  input  logic              clear,        // frame finished: rewind to the frame base
  output logic              last_col,
  output logic              last_row,
  output logic              mid_row,
  output logic [ADDR_W-1:0] addr          // address of the byte emitted this cycle
);

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
  localparam logic [11:0]       LAST_COL   = 12'(width - 1);
  localparam logic [31:0]       LAST_ROW   = 32'(height - 1);
  localparam logic              HAS_HEIGHT = (height != 0);

  logic [11:0]       col;
  logic [31:0]       row;
  logic [ADDR_W-1:0] row_start;
  logic [ADDR_W-1:0] next_addr;

  logic [11:0]       col_e;
  logic [31:0]       row_e;
  logic [ADDR_W-1:0] rs_e;
  logic [ADDR_W-1:0] addr_e;

  // Effective position of an accepted pixel after vsync/hsync overrides.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    col_e  = col;
    row_e  = row;
    rs_e   = row_start;
    addr_e = next_addr;
    if (start_frame) begin
      col_e  = '0;
      row_e  = '0;
      rs_e   = BASE;
      addr_e = BASE;
    end else if (abandon_row) begin
      col_e  = '0;
      row_e  = row + 32'd1;
      rs_e   = row_start + STRIDE_A;
      addr_e = row_start + STRIDE_A;
    end
  end

  assign addr    = take_pixel ? addr_e : next_addr;
  assign mid_row = (col != '0);

  // Advance the position counters per pixel and the address per emitted byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      row_start <= BASE;
      next_addr <= BASE;
      last_col  <= 1'b0;
      last_row  <= 1'b0;
    end else if (clear) begin
      col       <= '0;
      row       <= '0;
      row_start <= BASE;
      next_addr <= BASE;
      last_col  <= 1'b0;
      last_row  <= 1'b0;
    end else begin
      if (take_pixel) begin
        last_col <= (col_e == LAST_COL);
        last_row <= HAS_HEIGHT && (row_e == LAST_ROW);
        if (col_e == LAST_COL) begin
          col       <= '0;
          row       <= row_e + 32'd1;
          row_start <= rs_e + STRIDE_A;
        end else begin
          col       <= col_e + 12'd1;
          row       <= row_e;
          row_start <= rs_e;
        end
      end
      if (take_pixel || next_byte) begin
        next_addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bmp_frame_writer.sv
// Pixel-stream sink that unpacks 24-bit pixels into little-endian byte
// writes for a BMP-layout frame buffer.
// Build option: ROW_PAD_EN enables zero padding of each row to a 4-byte
// boundary; without it rows are packed back to back.
module bmp_frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned width     = 32'd640,
  parameter int unsigned height    = 32'd480,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 24
) (
  input  logic                clk,
  input  logic                reset,
  bmp_frame_writer_if.slave   bus,
  output logic                frame_done,
  output logic                row_err
);

`ifdef ROW_PAD_EN
  localparam logic [1:0] PAD_BYTES = row_pad(width);
`else
  localparam logic [1:0] PAD_BYTES = 2'd0;
`endif
  localparam int unsigned       STRIDE = BYTES_PER_PIXEL * width + int'(PAD_BYTES);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

  state_t               state;
  state_t               state_nxt;
  logic [15:0]          pix_hi;
  logic [1:0]           pad_cnt;
  logic [1:0]           pad_cnt_nxt;
  logic                 we_nxt;
  logic [WORD_SIZE-1:0] wdata_nxt;
  logic                 done_nxt;
  logic                 adv;
  logic                 clear;

  logic                 accept;
  logic                 abandon;
  logic                 last_col;
  logic                 last_row;
  logic                 mid_row;
  logic [ADDR_W-1:0]    byte_addr;
  logic                 row_pad_cur;
  logic                 frame_end_cur;

  assign accept        = bus.en && bus.ready;
  assign abandon       = accept && bus.hsync && !bus.vsync && mid_row;
  assign row_pad_cur   = last_col && (PAD_BYTES != 2'd0);
  assign frame_end_cur = last_col && last_row;

  frame_addr_gen #(
    .width     (width),
    .height    (height),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W),
    .STRIDE    (STRIDE)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .next_byte   (adv),
    .take_pixel  (accept),
    .start_frame (accept && bus.vsync),
    .abandon_row (abandon),
    .clear       (clear),
    .last_col    (last_col),
    .last_row    (last_row),
    .mid_row     (mid_row),
    .addr        (byte_addr)
  );

  // Ready: idle, or finishing byte 2 when no pad or frame end has to follow.
  always_comb begin
    bus.ready = 1'b0;
    case (state)
      IDLE:    bus.ready = 1'b1;
      B2:      bus.ready = !(row_pad_cur || frame_end_cur);
      default: bus.ready = 1'b0;
    endcase
    if (reset) bus.ready = 1'b0;
  end

  // Next state plus the values the registered memory port takes next cycle.
  always_comb begin
    state_nxt   = state;
    pad_cnt_nxt = pad_cnt;
    we_nxt      = 1'b0;
    wdata_nxt   = '0;
    done_nxt    = 1'b0;
    adv         = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = B0;
          we_nxt    = 1'b1;
          wdata_nxt = bus.data[7:0];
        end
      end
      B0: begin
        state_nxt = B1;
        we_nxt    = 1'b1;
        wdata_nxt = pix_hi[7:0];
        adv       = 1'b1;
      end
      B1: begin
        state_nxt = B2;
        we_nxt    = 1'b1;
        wdata_nxt = pix_hi[15:8];
        adv       = 1'b1;
      end
      B2: begin
        if (accept) begin
          state_nxt = B0;
          we_nxt    = 1'b1;
          wdata_nxt = bus.data[7:0];
        end else if (row_pad_cur) begin
          state_nxt   = PAD;
          we_nxt      = 1'b1;
          adv         = 1'b1;
          pad_cnt_nxt = 2'd1;
        end else if (frame_end_cur) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      PAD: begin
        if (pad_cnt == PAD_BYTES) begin
          if (frame_end_cur) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          we_nxt      = 1'b1;
          adv         = 1'b1;
          pad_cnt_nxt = pad_cnt + 2'd1;
        end
      end
      DONE: begin
        clear     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched pixel and registered outputs; reset drops any pending bytes.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state         <= IDLE;
      pix_hi        <= '0;
      pad_cnt       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE;
      bus.mem_wdata <= '0;
      frame_done    <= 1'b0;
      row_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      pad_cnt       <= pad_cnt_nxt;
      bus.mem_we    <= we_nxt;
      bus.mem_wdata <= wdata_nxt;
      frame_done    <= done_nxt;
      if (we_nxt) bus.mem_addr <= byte_addr;
      if (accept) pix_hi <= bus.data[23:8];
      if (accept && bus.vsync) row_err <= 1'b0;
      else if (abandon)        row_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bmp_frame_writer.sv
// Directed bench for bmp_frame_writer: width=3, height=2, base 0x10.
// Expectations follow the ROW_PAD_EN setting of the build.
module tb_bmp_frame_writer;

  localparam int unsigned ADDR_W = 24;
`ifdef ROW_PAD_EN
  localparam int PADB = 3;
`else
  localparam int PADB = 0;
`endif
  localparam int ROWB = 9 + PADB;   // bytes per row in memory

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_done;
  logic row_err;

  bmp_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

  bmp_frame_writer #(
    .width     (3),
    .height    (2),
    .BASE_ADDR (32'h10),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_done (frame_done),
    .row_err    (row_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_done = 0;
  int done_cyc = 0;
  logic [23:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  logic        wr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write and frame_done pulse mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      wc.push_back(cyc);
      wr.push_back(bus.ready);
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] px(input int i);
    logic [7:0] b0;
    b0 = 8'(8'h30 + 3 * i);
    return {b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); wr.delete();
    n_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
  endtask

  // Present one pixel and hold it until accepted; returns the accept cycle.
  task automatic send_px(input logic [23:0] d, input logic hs, input logic vs, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.en = 1'b1; bus.data = d; bus.hsync = hs; bus.vsync = vs;
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.en = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0;
  endtask

  function automatic int count_range(input int lo, input int hi);
    int n;
    n = 0;
    foreach (wa[i]) if (int'(wa[i]) >= lo && int'(wa[i]) <= hi) n++;
    return n;
  endfunction

  initial begin
    int acc;
    int n;
    bus.en = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.data = '0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'h10);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_rowerr", 32'(row_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.ready), 32'd1);

    // Single pixel with vsync: C3, B2, A1 at 0x10..0x12, latency 1/2/3.
    clear_log();
    send_px(24'hA1B2C3, 1'b0, 1'b1, acc);
    repeat (6) @(negedge clk);
    check("single_nwr", 32'(wa.size()), 32'd3);
    check("single_a0", 32'(wa[0]), 32'h10);
    check("single_d0", 32'(wd[0]), 32'hC3);
    check("single_a1", 32'(wa[1]), 32'h11);
    check("single_d1", 32'(wd[1]), 32'hB2);
    check("single_a2", 32'(wa[2]), 32'h12);
    check("single_d2", 32'(wd[2]), 32'hA1);
    check("single_lat0", 32'(wc[0] - acc + 1), 32'd1);
    check("single_lat2", 32'(wc[2] - acc + 1), 32'd3);

    // One row of three back-to-back pixels.
    do_reset();
    for (int i = 0; i < 3; i++) send_px(px(i), 1'b0, (i == 0), acc);
    repeat (10) @(negedge clk);
    check("row_nwr", 32'(wa.size()), 32'(9 + PADB));
    for (int j = 0; j < 9 + PADB; j++) begin
      check($sformatf("row_a%0d", j), 32'(wa[j]), 32'(16 + j));
      check($sformatf("row_d%0d", j), 32'(wd[j]), (j < 9) ? 32'(8'h30 + j) : 32'd0);
      check($sformatf("row_c%0d", j), 32'(wc[j] - wc[0]), 32'(j));
      if (j >= 9) check($sformatf("pad_ready%0d", j), 32'(wr[j]), 32'd0);
    end
    check("row_no_done", 32'(n_done), 32'd0);

    // Two full rows, then a new frame.
    do_reset();
    for (int i = 0; i < 6; i++) send_px(px(i), 1'b0, (i == 0), acc);
    repeat (12) @(negedge clk);
    n = wa.size();
    check("frame_nwr", 32'(n), 32'(2 * ROWB));
    check("row2_start", 32'(wa[ROWB]), 32'(16 + ROWB));
    check("row2_d0", 32'(wd[ROWB]), 32'h39);
    check("frame_last_a", 32'(wa[2 * ROWB - 1]), 32'(16 + 2 * ROWB - 1));
    check("frame_done_n", 32'(n_done), 32'd1);
    check("frame_done_t", 32'(done_cyc - wc[2 * ROWB - 1]), 32'd1);
    check("pad_bytes", 32'(count_range(16 + 9, 16 + ROWB - 1)), 32'(PADB));
    send_px(24'h0000EE, 1'b0, 1'b1, acc);
    repeat (6) @(negedge clk);
    check("next_frame_a", 32'(wa[2 * ROWB]), 32'h10);
    check("next_frame_d", 32'(wd[2 * ROWB]), 32'hEE);
    check("next_frame_done_n", 32'(n_done), 32'd1);

    // hsync on the third pixel of row 0 abandons the row.
    do_reset();
    send_px(px(0), 1'b0, 1'b1, acc);
    send_px(px(1), 1'b0, 1'b0, acc);
    send_px(px(2), 1'b1, 1'b0, acc);
    repeat (8) @(negedge clk);
    check("hs_rowerr", 32'(row_err), 32'd1);
    check("hs_nwr", 32'(wa.size()), 32'd9);
    check("hs_a6", 32'(wa[6]), 32'(16 + ROWB));
    check("hs_a8", 32'(wa[8]), 32'(16 + ROWB + 2));
    check("hs_d6", 32'(wd[6]), 32'h36);
    check("hs_gap", 32'(count_range(16 + 6, 16 + ROWB - 1)), 32'd0);
    send_px(px(3), 1'b1, 1'b1, acc);
    repeat (5) @(negedge clk);
    check("hs_rowerr_clr", 32'(row_err), 32'd0);
    check("hs_vs_addr", 32'(wa[9]), 32'h10);

    // Reset asserted while byte 1 is on the bus.
    do_reset();
    send_px(24'hA1B2C3, 1'b0, 1'b1, acc);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_we", 32'(bus.mem_we), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_b2", 32'(count_range(32'h12, 32'h12)), 32'd0);
    check("midrst_nwr", 32'(wa.size()), 32'd1);
    check("midrst_ready_after", 32'(bus.ready), 32'd1);
    check("midrst_addr_after", 32'(bus.mem_addr), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case something above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
